// File: rtl/des_pkg.sv
// Shared definitions for the DES CBC chaining wrapper: block width and FSM states.
package des_pkg;

    localparam int BLOCK_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/des_cbc.sv
// CBC chaining wrapper placed in front of an external DES core (IDLE/WAIT handshake).
// Optional per-block ECB bypass is compiled in when DES_CBC_ECB_EN is defined.
module des_cbc
    import des_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               mode_i,
    input  logic               start_i,
`ifdef DES_CBC_ECB_EN
    input  logic               ecb_i,
`endif
    input  logic [0:BLOCK_W-1] iv_i,
    input  logic [0:BLOCK_W-1] key_i,
    input  logic [0:BLOCK_W-1] data_i,
    input  logic               valid_i,
    output logic               accept_o,
    output logic               des_mode_o,
    output logic [0:BLOCK_W-1] des_key_o,
    output logic [0:BLOCK_W-1] des_data_o,
    output logic               des_valid_o,
    input  logic [0:BLOCK_W-1] des_data_i,
    input  logic               des_valid_i,
    output logic [0:BLOCK_W-1] data_o,
    output logic               valid_o
);

    state_t r_state;
    state_t w_next;

    logic               w_accept;
    logic               w_done;
    logic               w_ecb;
    logic               w_ecbDone;
    logic [0:BLOCK_W-1] w_chainEff;
    logic [0:BLOCK_W-1] w_chainDone;
    logic [0:BLOCK_W-1] r_chain;
    logic [0:BLOCK_W-1] r_cipher;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (valid_i)     w_next = ST_WAIT;
            ST_WAIT: if (des_valid_i) w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        accept_o = (r_state == ST_IDLE);
    end

    assign w_accept = valid_i & accept_o;
    assign w_done   = (r_state == ST_WAIT) & des_valid_i;

`ifdef DES_CBC_ECB_EN
    logic r_ecb;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ecb <= 1'b0;
        end else if (w_accept) begin
            r_ecb <= ecb_i;
        end
    end

    assign w_ecb     = ecb_i;
    assign w_ecbDone = r_ecb;
`else
    assign w_ecb     = 1'b0;
    assign w_ecbDone = 1'b0;
`endif

    // The chain register already holds iv_i once a start block is accepted,
    // so completion only needs to know whether the block bypassed chaining.
    assign w_chainEff  = w_ecb ? '0 : (start_i ? iv_i : r_chain);
    assign w_chainDone = w_ecbDone ? '0 : r_chain;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            des_mode_o  <= 1'b0;
            des_key_o   <= '0;
            des_data_o  <= '0;
            des_valid_o <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            r_chain     <= '0;
            r_cipher    <= '0;
        end else begin
            des_valid_o <= w_accept;
            valid_o     <= w_done;
            if (w_accept) begin
                des_mode_o <= mode_i;
                des_key_o  <= key_i;
                if (mode_i) begin
                    des_data_o <= data_i;
                    r_cipher   <= data_i;
                end else begin
                    des_data_o <= data_i ^ w_chainEff;
                end
                if (start_i && !w_ecb) begin
                    r_chain <= iv_i;
                end
            end
            // Decrypt chains on the held ciphertext, encrypt on the core result.
            if (w_done) begin
                if (des_mode_o) begin
                    data_o <= des_data_i ^ w_chainDone;
                    if (!w_ecbDone) begin
                        r_chain <= r_cipher;
                    end
                end else begin
                    data_o <= des_data_i;
                    if (!w_ecbDone) begin
                        r_chain <= des_data_i;
                    end
                end
            end
        end
    end

endmodule
